// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared constants for the syn_ram-backed FWFT FIFO controller.
// Optional status outputs are enabled by defining FIFO_CTRL_STATUS_EN.
package fifo_ctrl_pkg;

    localparam int FIFO_DATA_W          = 8;
    localparam int FIFO_ADDR_W          = 8;
    localparam int FIFO_ALMOST_FULL_LVL = 240;

    // Pointers carry one extra wrap bit above the RAM address bits so that
    // full and empty can be told apart when the address bits match.
    function automatic int fifo_ptr_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/fifo_ctrl_ptr.sv
// fifo_ptr: wrapping pointer register (address bits plus wrap bit) used for
// both the write and read side of fifo_ctrl. Not affected by FIFO_CTRL_STATUS_EN.
module fifo_ptr
    import fifo_ctrl_pkg::*;
#(
    parameter int W = fifo_ptr_w(FIFO_ADDR_W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // Advance by one on each accepted transfer; natural overflow toggles the wrap bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller turning an external syn_ram into a
// first-word-fall-through FIFO. The RAM is instantiated by the parent.
// Define FIFO_CTRL_STATUS_EN to add the almost_full and sticky overflow outputs.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_W,
    parameter int ADDR_WIDTH = FIFO_ADDR_W
`ifdef FIFO_CTRL_STATUS_EN
    ,
    parameter int ALMOST_FULL_LVL = FIFO_ALMOST_FULL_LVL
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] ram_addr_in,
    output logic [ADDR_WIDTH-1:0] ram_addr_out,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_write_enable,
    input  logic [DATA_WIDTH-1:0] ram_data_out
`ifdef FIFO_CTRL_STATUS_EN
    ,
    output logic                  almost_full,
    output logic                  overflow
`endif
);

    localparam int PTR_W = fifo_ptr_w(ADDR_WIDTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] count_next;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    fifo_ptr #(.W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop),
        .ptr (rd_ptr)
    );

    // Flags come only from registered pointers, so neither handshake side
    // depends combinationally on the other side's valid/ready.
    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
        wr_ready = !full && !rst;
        rd_valid = !empty && !rst;
        push     = wr_valid && wr_ready;
        pop      = rd_valid && rd_ready;
    end

    // RAM port wiring; read data falls through from the read pointer address.
    always_comb begin
        ram_addr_in      = wr_ptr[ADDR_WIDTH-1:0];
        ram_addr_out     = rd_ptr[ADDR_WIDTH-1:0];
        ram_data_in      = wr_data;
        ram_write_enable = push;
        rd_data          = ram_data_out;
    end

    // Occupancy after this cycle's transfers; simultaneous push and pop cancel.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + PTR_W'(1);
            2'b01:   count_next = count - PTR_W'(1);
            default: count_next = count;
        endcase
    end

    // Occupancy register, tracking wr_ptr - rd_ptr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

`ifdef FIFO_CTRL_STATUS_EN
    // almost_full moves in step with count; overflow latches any write attempt while full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            almost_full <= (count_next >= PTR_W'(ALMOST_FULL_LVL));
            if (wr_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Pointer/flag controller that turns the team's dual-port RAM block `syn_ram` into a first-word-fall-through FIFO. It drives the RAM's write port and read address, and consumes the RAM's combinational read data. It presents valid/ready handshakes on both sides. It sits between the bus/UART producer and any consumer needing byte buffering.

Parameters:
- DATA_WIDTH, 8, width of each FIFO entry; must match the attached `syn_ram`.
- ADDR_WIDTH, 8, RAM address width; depth is 2**ADDR_WIDTH entries (256 by default).
- ALMOST_FULL_LVL, 240, occupancy at or above which almost_full asserts. Used only with FIFO_CTRL_STATUS_EN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  producer has data on wr_data.
- wr_ready  out  1  FIFO can accept an entry this cycle.
- wr_data  in  DATA_WIDTH  write payload.
- rd_valid  out  1  rd_data holds the oldest entry.
- rd_ready  in  1  consumer takes the entry this cycle.
- rd_data  out  DATA_WIDTH  oldest entry; passed through from ram_data_out.
- count  out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
- ram_addr_in  out  ADDR_WIDTH  RAM write address (write pointer).
- ram_addr_out  out  ADDR_WIDTH  RAM read address (read pointer).
- ram_data_in  out  DATA_WIDTH  equals wr_data.
- ram_write_enable  out  1  equals push.
- ram_data_out  in  DATA_WIDTH  RAM combinational read data.
- almost_full  out  1  present only with FIFO_CTRL_STATUS_EN.
- overflow  out  1  present only with FIFO_CTRL_STATUS_EN.

Behaviour:
- State:
  - wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits (MSB is the wrap bit).
  - count register.
  - All three are cleared to 0 asynchronously when rst rises.
- Flags:
  - empty = (wr_ptr == rd_ptr).
  - full = (address bits equal) and (wrap bits differ).
  - count must always equal wr_ptr - rd_ptr, taken modulo 2**(ADDR_WIDTH+1).
- Handshake outputs:
  - wr_ready = !full && !rst.
  - rd_valid = !empty && !rst.
  - Both are 0 while rst is high; after reset, wr_ready=1 and rd_valid=0.
- Transfers:
  - push = wr_valid && wr_ready.
  - pop = rd_valid && rd_ready.
  - Push: RAM writes wr_data at wr_ptr[ADDR_WIDTH-1:0]; wr_ptr increments.
  - Pop: rd_ptr increments.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Wrap-around: pointers increment modulo 2**(ADDR_WIDTH+1); address bits wrap from 2**ADDR_WIDTH-1 to 0 and the wrap bit toggles.
- Latency:
  - A word pushed at edge N makes rd_valid=1 after edge N (one cycle, empty case).
  - rd_data is combinational from the RAM at rd_ptr, so a pop at edge N shows the next word right after edge N.
- Full boundary: push is refused even if a pop happens in the same cycle (wr_ready depends only on registered state). The pop completes; the producer retries next cycle.
- Empty boundary: a push into an empty FIFO is not readable in the same cycle; no bypass.
- Reset mid-operation: any transfer in the reset cycle is discarded; RAM contents are not cleared.
- No handshake signal may depend combinationally on the opposite side's valid/ready.

Optional Feature:
- Macro: FIFO_CTRL_STATUS_EN.
- Defined:
  - almost_full = (count >= ALMOST_FULL_LVL), registered, updated with count.
  - overflow is a sticky flag set when wr_valid && full at a rising edge. Only rst clears it. Both reset to 0.
- Undefined: both ports and their logic are absent; no other behaviour changes.

Decomposition:
- Shared package/include holds:
  - the default DATA_WIDTH/ADDR_WIDTH constants;
  - a FIFO_PTR_W = ADDR_WIDTH+1 localparam rule.
- One sub-module, fifo_ptr: a pointer register with async reset, increment enable and wrap bit. Instantiated twice (write and read side).
- `syn_ram` is instantiated by the parent, not inside fifo_ctrl.

Test Plan:
- Reset then idle → wr_ready=1, rd_valid=0, count=0, ram_write_enable=0.
- Push 0xA5 at edge 1 → after edge 1: rd_valid=1, rd_data=0xA5, count=1. Pop → rd_valid=0, count=0.
- Push 256 entries 0x00..0xFF with rd_ready=0 → wr_ready=0 and count=256 after the 256th push. Extra wr_valid is refused. With STATUS_EN: overflow=1, almost_full=1 once count reaches 240.
- Full FIFO with wr_valid=1 and rd_ready=1 in the same cycle → only the pop occurs, count=255, wr_ready=1 next cycle.
- Stream 600 words with simultaneous push/pop at depth 3 → the data sequence is preserved across pointer wrap; count stays at 3.
- Assert rst mid-stream (count=17) → all outputs return to reset values immediately; first push after release reads back correctly at address 0.
